mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the 5-stage pipeline. Consumes the 107-bit EX/MEM bundle, accesses an internal word-addressed data RAM, resolves the branch select, and registers the 71-bit MEM/WB bundle for write-back.
- Includes stall/flush control from the hazard unit.

Parameters:
- ADDR_W, 8, word-address width; RAM depth = 2**ADDR_W 32-bit words.

Ports:
- clk  input  1  clock, rising edge.
- clr  input  1  asynchronous, active-low reset.
- in  input  107  EX/MEM bundle: [0] zero, [1] RegWrite, [2] MemToReg, [3] MemWrite, [4] BranchEq, [5] Jump, [10:6] writeReg, [42:11] alu_out, [74:43] writeData, [106:75] pcBranch.
- stall  input  1  hold MEM/WB register, suppress store.
- flush  input  1  insert bubble into MEM/WB, suppress store.
- pcSrc  output  1  combinational BranchEq & zero.
- jumpOut  output  1  combinational copy of in[5].
- pcBranchOut  output  32  combinational copy of in[106:75].
- out  output  71  MEM/WB bundle: [0] RegWrite, [1] MemToReg, [6:2] writeReg, [38:7] alu_out, [70:39] readData.
- mem_err  output  1  sticky misalignment flag; present only with the optional feature, otherwise tied 0.

Behaviour:
- Reset (clr=0, async): out=0, mem_err=0. RAM contents are not reset. Reset asserted mid-operation clears out immediately and blocks any store on that edge.
- Address: word index = alu_out[ADDR_W+1:2]. Upper bits are ignored, so addresses wrap modulo depth.
- Read: combinational from RAM at the word index, captured into out[70:39] at the rising edge. One-cycle latency from bundle at `in` to readData at `out`.
- Store: on rising edge, when MemWrite=1, stall=0 and flush=0, RAM[index] <= writeData.
- Load and store to the same address on the same edge: captured readData is the pre-store (old) contents.
- MEM/WB update on each rising edge, priority flush > stall > normal:
  - flush=1: out <= 0 (bubble; RegWrite=0).
  - stall=1: out holds its value; no store.
  - normal: out <= {readData, alu_out, writeReg, MemToReg, RegWrite} from the current input.
- pcSrc, jumpOut, pcBranchOut are purely combinational from `in` and are unaffected by stall, flush or reset.
- A store instruction (RegWrite=0, MemToReg=0) still propagates its alu_out and writeReg fields unchanged.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- When defined:
  - Any access with alu_out[1:0] != 0 and (MemWrite=1 or MemToReg=1) and not stalled/flushed suppresses the store.
  - The same access forces captured readData to 0.
  - It sets mem_err=1 on that edge; mem_err stays 1 until clr.
- When undefined:
  - alu_out[1:0] are ignored.
  - Misaligned accesses behave as the aligned word.
  - mem_err is constant 0.

Test Plan:
- Reset: drive clr=0 with in all ones -> out=0 immediately; pcSrc=1, jumpOut=1, pcBranchOut=0xFFFFFFFF.
- Store then load: store alu_out=0x10, writeData=0xDEADBEEF, then load 0x10 with MemToReg=1, RegWrite=1, writeReg=5 -> one cycle later out[70:39]=0xDEADBEEF, out[6:2]=5, out[1:0]=2'b11.
- Wrap (ADDR_W=8): store 0xA5A5A5A5 at 0x400, load 0x0 -> readData=0xA5A5A5A5.
- Stall/flush: store 0x11111111 at 0x20 with stall=1 -> subsequent load of 0x20 returns the prior value and out holds. Assert stall and flush together -> out=0 and no store.
- Branch: BranchEq=1, zero=1 -> pcSrc=1. BranchEq=1, zero=0 -> pcSrc=0. pcBranchOut=0x00400040 passes through the same cycle.
- With MEM_ALIGN_CHECK_EN: store at 0x22 -> RAM unchanged, mem_err=1 after the edge and still 1 after ten aligned accesses. Without the macro, the same store writes word 0x20.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage, data RAM and MEM/WB register.
// Optional: MEM_ALIGN_CHECK_EN traps misaligned loads/stores.
package mem_pkg;

  typedef struct packed {
    logic [31:0] pc_branch;
    logic [31:0] write_data;
    logic [31:0] alu_out;
    logic [4:0]  write_reg;
    logic        jump;
    logic        branch_eq;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic        zero;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] read_data;
    logic [31:0] alu_out;
    logic [4:0]  write_reg;
    logic        mem_to_reg;
    logic        reg_write;
  } mem_wb_t;

endpackage

module mem_stage #(
  parameter int ADDR_W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [106:0] in,
  input  logic         stall,
  input  logic         flush,
  output logic         pcSrc,
  output logic         jumpOut,
  output logic [31:0]  pcBranchOut,
  output logic [70:0]  out,
  output logic         mem_err
);

  import mem_pkg::*;

  localparam int DEPTH = 1 << ADDR_W;

  ex_mem_t           b;
  mem_wb_t           wb_d;
  mem_wb_t           wb_q;
  logic [31:0]       ram [0:DEPTH-1];
  logic [ADDR_W-1:0] idx;
  logic [31:0]       rd_raw;
  logic [31:0]       rd;
  logic              adv;
  logic              mis;
  logic              we;

  assign b = ex_mem_t'(in);

  // Branch/jump resolution bypasses the pipeline register.
  assign pcSrc       = b.branch_eq & b.zero;
  assign jumpOut     = b.jump;
  assign pcBranchOut = b.pc_branch;

  // Word index; upper address bits wrap.
  assign idx    = b.alu_out[ADDR_W+1:2];
  assign rd_raw = ram[idx];
  assign adv    = ~stall & ~flush;

`ifdef MEM_ALIGN_CHECK_EN
  assign mis = (|b.alu_out[1:0]) &
               (b.mem_write | b.mem_to_reg);
`else
  assign mis = 1'b0;
`endif

  assign we = b.mem_write & adv & ~mis;
  assign rd = mis ? 32'h0 : rd_raw;

  // Store port; reset held low at the edge blocks the write.
  always_ff @(posedge clk) begin
    if (clr && we) begin
      ram[idx] <= b.write_data;
    end
  end

  // Next MEM/WB value: flush beats stall beats advance.
  always_comb begin
    wb_d = wb_q;
    if (flush) begin
      wb_d = '0;
    end else if (stall) begin
      wb_d = wb_q;
    end else begin
      wb_d.read_data  = rd;
      wb_d.alu_out    = b.alu_out;
      wb_d.write_reg  = b.write_reg;
      wb_d.mem_to_reg = b.mem_to_reg;
      wb_d.reg_write  = b.reg_write;
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  assign out = wb_q;

`ifdef MEM_ALIGN_CHECK_EN
  logic err_q;

  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      err_q <= 1'b0;
    end else if (mis && adv) begin
      err_q <= 1'b1;
    end
  end

  assign mem_err = err_q;
`else
  assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven check of mem_stage.
// Covers store/load, wrap, stall/flush, branch, reset, alignment.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         clr;
  logic [106:0] in;
  logic         stall;
  logic         flush;
  logic         pcSrc;
  logic         jumpOut;
  logic [31:0]  pcBranchOut;
  logic [70:0]  out;
  logic         mem_err;

  int n_cmp = 0;
  int n_err = 0;

  mem_stage #(.ADDR_W(8)) dut (
    .clk         (clk),
    .clr         (clr),
    .in          (in),
    .stall       (stall),
    .flush       (flush),
    .pcSrc       (pcSrc),
    .jumpOut     (jumpOut),
    .pcBranchOut (pcBranchOut),
    .out         (out),
    .mem_err     (mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [106:0] in;
    logic         stall;
    logic         flush;
    logic         pcsrc;
    logic [70:0]  exp;
    logic [70:0]  mask;
  } vec_t;

  localparam logic [70:0] M_ALL = '1;
  localparam logic [70:0] M_LO  = 71'h7F_FFFF_FFFF;

  function automatic logic [106:0] mk(
    logic [31:0] pcb, logic [31:0] wd, logic [31:0] alu,
    logic [4:0] wr, logic j, logic beq, logic mw,
    logic m2r, logic rw, logic z);
    return {pcb, wd, alu, wr, j, beq, mw, m2r, rw, z};
  endfunction

  function automatic logic [70:0] ex(
    logic [31:0] rd, logic [31:0] alu,
    logic [4:0] wr, logic m2r, logic rw);
    return {rd, alu, wr, m2r, rw};
  endfunction

  function automatic vec_t row(
    logic [106:0] i, logic s, logic f, logic p,
    logic [70:0] e, logic [70:0] m);
    vec_t v;
    v.in = i; v.stall = s; v.flush = f;
    v.pcsrc = p; v.exp = e; v.mask = m;
    return v;
  endfunction

  task automatic chk(string nm, logic [70:0] act, logic [70:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  vec_t tv [16];

  initial begin
    logic [31:0] pcb;
    logic [31:0] d13;
    logic [31:0] d14;
    logic        me;

    pcb = 32'h0040_0040;
`ifdef MEM_ALIGN_CHECK_EN
    d13 = 32'h0;
    d14 = 32'hCAFE_F00D;
    me  = 1'b1;
`else
    d13 = 32'hCAFE_F00D;
    d14 = 32'h3333_3333;
    me  = 1'b0;
`endif

    // init stores (read data still unknown)
    tv[0]  = row(mk(0, 32'h1234_5678, 32'h0, 1, 0,0,1,0,0,0),
                 0, 0, 0, ex(0, 32'h0, 1, 0, 0), M_LO);
    tv[1]  = row(mk(0, 32'hDEAD_BEEF, 32'h10, 2, 0,0,1,0,0,0),
                 0, 0, 0, ex(0, 32'h10, 2, 0, 0), M_LO);
    tv[2]  = row(mk(0, 32'hCAFE_F00D, 32'h20, 3, 0,0,1,0,0,0),
                 0, 0, 0, ex(0, 32'h20, 3, 0, 0), M_LO);
    // load after store
    tv[3]  = row(mk(0, 0, 32'h10, 5, 0,0,0,1,1,0),
                 0, 0, 0, ex(32'hDEAD_BEEF, 32'h10, 5, 1, 1), M_ALL);
    // wrap store at 0x400; same-edge read returns old word
    tv[4]  = row(mk(0, 32'hA5A5_A5A5, 32'h400, 0, 0,0,1,0,0,0),
                 0, 0, 0, ex(32'h1234_5678, 32'h400, 0, 0, 0), M_ALL);
    tv[5]  = row(mk(0, 0, 32'h0, 7, 0,0,0,1,1,0),
                 0, 0, 0, ex(32'hA5A5_A5A5, 32'h0, 7, 1, 1), M_ALL);
    // stalled store: out holds, no write
    tv[6]  = row(mk(0, 32'h1111_1111, 32'h20, 8, 0,0,1,0,0,0),
                 1, 0, 0, ex(32'hA5A5_A5A5, 32'h0, 7, 1, 1), M_ALL);
    tv[7]  = row(mk(0, 0, 32'h20, 9, 0,0,0,1,1,0),
                 0, 0, 0, ex(32'hCAFE_F00D, 32'h20, 9, 1, 1), M_ALL);
    // stall+flush: bubble, no write
    tv[8]  = row(mk(0, 32'h2222_2222, 32'h20, 9, 0,0,1,0,0,0),
                 1, 1, 0, 71'h0, M_ALL);
    tv[9]  = row(mk(0, 0, 32'h20, 10, 0,0,0,1,1,0),
                 0, 0, 0, ex(32'hCAFE_F00D, 32'h20, 10, 1, 1), M_ALL);
    // branch resolution
    tv[10] = row(mk(pcb, 0, 32'h10, 0, 0,1,0,0,0,1),
                 0, 0, 1, ex(32'hDEAD_BEEF, 32'h10, 0, 0, 0), M_ALL);
    tv[11] = row(mk(pcb, 0, 32'h10, 0, 0,1,0,0,0,0),
                 0, 0, 0, ex(32'hDEAD_BEEF, 32'h10, 0, 0, 0), M_ALL);
    tv[12] = row(mk(32'h1234_0000, 0, 32'h10, 0, 1,0,0,0,0,1),
                 0, 0, 0, ex(32'hDEAD_BEEF, 32'h10, 0, 0, 0), M_ALL);
    // misaligned store at 0x22
    tv[13] = row(mk(0, 32'h3333_3333, 32'h22, 4, 0,0,1,0,0,0),
                 0, 0, 0, ex(d13, 32'h22, 4, 0, 0), M_ALL);
    tv[14] = row(mk(0, 0, 32'h20, 11, 0,0,0,1,1,0),
                 0, 0, 0, ex(d14, 32'h20, 11, 1, 1), M_ALL);
    // flush alone
    tv[15] = row(mk(0, 0, 32'h10, 12, 0,0,0,1,1,0),
                 0, 1, 0, 71'h0, M_ALL);

    // reset with all-ones bundle
    clr = 1'b0; stall = 1'b0; flush = 1'b0;
    in = '1;
    #1;
    chk("rst_out", out, 71'h0);
    chk("rst_err", {70'h0, mem_err}, 71'h0);
    chk("rst_pcsrc", {70'h0, pcSrc}, 71'h1);
    chk("rst_jump", {70'h0, jumpOut}, 71'h1);
    chk("rst_pcb", {39'h0, pcBranchOut}, {39'h0, 32'hFFFF_FFFF});
    @(negedge clk);
    @(negedge clk);
    in = '0;
    clr = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in = tv[i].in; stall = tv[i].stall; flush = tv[i].flush;
      #1;
      chk($sformatf("pcsrc[%0d]", i), {70'h0, pcSrc},
          {70'h0, tv[i].pcsrc});
      chk($sformatf("jump[%0d]", i), {70'h0, jumpOut},
          {70'h0, tv[i].in[5]});
      chk($sformatf("pcb[%0d]", i), {39'h0, pcBranchOut},
          {39'h0, tv[i].in[106:75]});
      @(posedge clk);
      #1;
      chk($sformatf("out[%0d]", i), out & tv[i].mask,
          tv[i].exp & tv[i].mask);
    end

    @(negedge clk);
    stall = 1'b0; flush = 1'b0;
    chk("err_after", {70'h0, mem_err}, {70'h0, me});

    // ten aligned loads: flag stays sticky
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in = mk(0, 0, 32'h0, 5'(k), 0,0,0,1,1,0);
      @(posedge clk);
      #1;
      chk($sformatf("aload[%0d]", k), out,
          ex(32'hA5A5_A5A5, 32'h0, 5'(k), 1, 1));
    end
    chk("err_sticky", {70'h0, mem_err}, {70'h0, me});

    // reset mid-operation clears out and blocks the store
    @(negedge clk);
    in = mk(0, 32'h5555_5555, 32'h10, 6, 0,0,1,0,0,0);
    clr = 1'b0;
    #1;
    chk("mid_rst_out", out, 71'h0);
    chk("mid_rst_err", {70'h0, mem_err}, 71'h0);
    @(posedge clk);
    #1;
    chk("mid_rst_hold", out, 71'h0);
    @(negedge clk);
    clr = 1'b1;
    in = mk(0, 0, 32'h10, 6, 0,0,0,1,1,0);
    @(posedge clk);
    #1;
    chk("mid_rst_load", out, ex(32'hDEAD_BEEF, 32'h10, 6, 1, 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
